// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and reset constants.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } lsu_state_e;

    localparam lsu_state_e  RST_STATE = ST_IDLE;
    localparam logic [31:0] RST_WORD  = 32'h0000_0000;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data from a DMEM word and
// merges sub-word store data into a DMEM word, for either byte order.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian lane 0 sits in the top bits, so the shift counts down with the offset.
    always_comb begin
        byte_shift = BIG_ENDIAN ? {~offset_i, 3'b000} : {offset_i, 3'b000};
        half_shift = BIG_ENDIAN ? {~offset_i[1], 4'b0000} : {offset_i[1], 4'b0000};
        byte_val   = 8'(rd_word_i >> byte_shift);
        half_val   = 16'(rd_word_i >> half_shift);
    end

    always_comb begin
        load_data_o = rd_word_i;
        merged_o    = wdata_i;
        if (size_i == SZ_BYTE) begin
            load_data_o = unsigned_i ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
            merged_o    = (rd_word_i & ~(32'h0000_00FF << byte_shift))
                        | (32'(wdata_i[7:0]) << byte_shift);
        end else if (size_i == SZ_HALF) begin
            load_data_o = unsigned_i ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
            merged_o    = (rd_word_i & ~(32'h0000_FFFF << half_shift))
                        | (32'(wdata_i[15:0]) << half_shift);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit driving a word-addressed DMEM with registered reads;
// sub-word stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        LSU_clk,
    input  logic        LSU_reset,
    input  logic        LSU_req_valid,
    output logic        LSU_req_ready,
    input  logic        LSU_req_write,
    input  logic [1:0]  LSU_req_size,
    input  logic        LSU_req_unsigned,
    input  logic [31:0] LSU_req_addr,
    input  logic [31:0] LSU_req_wdata,
    output logic [31:0] LSU_rdata,
    output logic        LSU_done,
    output logic        LSU_err,
    output logic [31:0] LSU_mem_address,
    output logic [31:0] LSU_mem_data_out,
    output logic        LSU_mem_write,
    output logic        LSU_mem_read,
    input  logic [31:0] LSU_mem_data_in
);

    // Handshake: a request transfers on a rising edge where LSU_req_valid and
    // LSU_req_ready are both high; ready is high exactly while the FSM is idle.

    lsu_state_e  state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [1:0]  offset_d;
    logic [31:0] index_d;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        unused_addr_bits;

    // Bits above the index alias onto the same DMEM word.
    assign unused_addr_bits = ^LSU_req_addr[31:INDEX_WIDTH+2];
    assign index_d          = 32'(LSU_req_addr[INDEX_WIDTH+1:2]);

    always_comb begin
        offset_d = 2'b00;
        if (LSU_req_size == SZ_BYTE) begin
            offset_d = LSU_req_addr[1:0];
        end else if (LSU_req_size == SZ_HALF) begin
            offset_d = {LSU_req_addr[1], 1'b0};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_d;
    logic err_q;

    assign misalign_d = (is_word(LSU_req_size) && (LSU_req_addr[1:0] != 2'b00))
                     || ((LSU_req_size == SZ_HALF) && LSU_req_addr[0]);
    assign LSU_err    = err_q;
`else
    assign LSU_err = 1'b0;
`endif

    lsu_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane_align (
        .rd_word_i  (LSU_mem_data_in),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .offset_i   (offset_q),
        .wdata_i    (wdata_q),
        .load_data_o(load_data),
        .merged_o   (merged)
    );

    always_ff @(posedge LSU_clk) begin
        if (LSU_reset) begin
            state_q     <= RST_STATE;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            offset_q    <= 2'b00;
            wdata_q     <= RST_WORD;
            mem_addr_q  <= RST_WORD;
            mem_wdata_q <= RST_WORD;
            rdata_q     <= RST_WORD;
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (LSU_req_valid) begin
                        write_q    <= LSU_req_write;
                        size_q     <= LSU_req_size;
                        unsigned_q <= LSU_req_unsigned;
                        offset_q   <= offset_d;
                        wdata_q    <= LSU_req_wdata;
                        mem_addr_q <= index_d;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign_d) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else
`endif
                        if (LSU_req_write && is_word(LSU_req_size)) begin
                            mem_wdata_q <= LSU_req_wdata;
                            mem_write_q <= 1'b1;
                            state_q     <= ST_WRITE;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (write_q) begin
                        mem_wdata_q <= merged;
                        mem_write_q <= 1'b1;
                        state_q     <= ST_WRITE;
                    end else begin
                        rdata_q <= load_data;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LSU_req_ready    = (state_q == ST_IDLE);
    assign LSU_rdata        = rdata_q;
    assign LSU_done         = done_q;
    assign LSU_mem_address  = mem_addr_q;
    assign LSU_mem_data_out = mem_wdata_q;
    assign LSU_mem_write    = mem_write_q;
    assign LSU_mem_read     = mem_read_q;

endmodule
